// File: rtl/nn_pkg.sv
// Shared definitions for the layer datapath: word width, loader/controller
// state encoding and a small elaboration-time helper.
package nn_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_IMG  = 2'd1,
      LOAD_BIAS = 2'd2,
      DRAIN     = 2'd3
   } loader_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/word_stager.sv
// N-word staging register file: one indexed write port, whole contents
// presented as a packed vector with word k at [k*W +: W].
module word_stager
   import nn_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = WORD_W,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [W-1:0]     wdata_i,
   output logic [N*W-1:0]   rdata_o
);

   logic [N-1:0][W-1:0] mem_q;

   // NOTE: this storage is reset on purpose -- a reset must leave every staged word at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else if (we_i) begin
         for (int i = 0; i < N; i++) begin
            if (idx_i == IDX_W'(i)) mem_q[i] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q;

endmodule

// File: rtl/layer_loader.sv
// Serial stream to packed image/bias loader. Stages a frame of NUM_IN image
// words then NUM_OUT bias words and commits both atomically on a good frame.
module layer_loader
   import nn_pkg::*;
#(
   parameter int NUM_IN  = 4,
   parameter int NUM_OUT = 4,
   parameter int DATA_W  = WORD_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_W-1:0]         s_data,
   input  logic                      s_last,
   output logic [NUM_IN*DATA_W-1:0]  image,
   output logic [NUM_OUT*DATA_W-1:0] bias,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   localparam int CNT_W = $clog2(max3(NUM_IN, NUM_OUT, 2));
   localparam logic [CNT_W-1:0] IMG_LAST  = CNT_W'(NUM_IN - 1);
   localparam logic [CNT_W-1:0] BIAS_LAST = CNT_W'(NUM_OUT - 1);

   loader_state_t               state_q;
   logic [CNT_W-1:0]            cnt_q;
   logic                        ready_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        error_q;
   logic [NUM_IN*DATA_W-1:0]    image_q;
   logic [NUM_OUT*DATA_W-1:0]   bias_q;

   logic [NUM_IN*DATA_W-1:0]    stage_img;
   logic [NUM_OUT*DATA_W-1:0]   stage_bias;
   logic [NUM_OUT*DATA_W-1:0]   bias_commit_d;
   logic                        beat;
   logic                        img_we;
   logic                        bias_we;

   assign beat    = s_valid && ready_q;
   assign img_we  = beat && (state_q == LOAD_IMG);
   assign bias_we = beat && (state_q == LOAD_BIAS);

   word_stager #(.N(NUM_IN), .W(DATA_W), .IDX_W(CNT_W)) u_img_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (img_we),
      .idx_i   (cnt_q),
      .wdata_i (s_data),
      .rdata_o (stage_img)
   );

   word_stager #(.N(NUM_OUT), .W(DATA_W), .IDX_W(CNT_W)) u_bias_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (bias_we),
      .idx_i   (cnt_q),
      .wdata_i (s_data),
      .rdata_o (stage_bias)
   );

   // The final bias word is still on the bus when the frame commits.
   // NOTE: blocking '=' in always_comb, with the full default first so no latch is inferred.
   always_comb begin
      bias_commit_d = stage_bias;
      bias_commit_d[(NUM_OUT-1)*DATA_W +: DATA_W] = s_data;
   end

   // NOTE: all sequential state uses '<=' so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         image_q <= '0;
         bias_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= LOAD_IMG;
                  cnt_q   <= '0;
                  error_q <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            LOAD_IMG: begin
               if (beat) begin
                  if (s_last) begin
                     error_q <= 1'b1;
                     state_q <= IDLE;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end else if (cnt_q == IMG_LAST) begin
                     state_q <= LOAD_BIAS;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            LOAD_BIAS: begin
               if (beat) begin
                  if (cnt_q == BIAS_LAST) begin
                     if (s_last) begin
                        image_q <= stage_img;
                        bias_q  <= bias_commit_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                     end else begin
                        error_q <= 1'b1;
                        state_q <= DRAIN;
                     end
                  end else if (s_last) begin
                     error_q <= 1'b1;
                     state_q <= IDLE;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (beat && s_last) begin
                  state_q <= IDLE;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready = ready_q;
   assign image   = image_q;
   assign bias    = bias_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule

// File: tb/tb_layer_loader.sv
// Bench for layer_loader: a 2/2 and a 1/3 instance share one stream and are
// checked every cycle against a frame-level model, plus literal spot checks.
module tb_layer_loader;

   localparam int FRAME = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;

   logic        s_ready_a, busy_a, done_a, error_a;
   logic [63:0] image_a, bias_a;
   logic        s_ready_b, busy_b, done_b, error_b;
   logic [31:0] image_b;
   logic [95:0] bias_b;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;

   always #5 clk = ~clk;

   layer_loader #(.NUM_IN(2), .NUM_OUT(2), .DATA_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready_a),
      .s_data(s_data), .s_last(s_last), .image(image_a), .bias(bias_a),
      .busy(busy_a), .done(done_a), .error(error_a)
   );

   layer_loader #(.NUM_IN(1), .NUM_OUT(3), .DATA_W(32)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready_b),
      .s_data(s_data), .s_last(s_last), .image(image_b), .bias(bias_b),
      .busy(busy_b), .done(done_b), .error(error_b)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: a frame is the list of accepted words up to s_last or
   // FRAME words; its length and s_last position decide commit or error.
   logic        m_active = 1'b0;
   logic        m_drain  = 1'b0;
   logic        m_err    = 1'b0;
   logic        m_done   = 1'b0;
   int          m_n      = 0;
   logic [31:0] m_w [0:FRAME-1];
   logic [63:0] m_img_a  = '0;
   logic [63:0] m_bias_a = '0;
   logic [31:0] m_img_b  = '0;
   logic [95:0] m_bias_b = '0;
   logic        m_ready;

   assign m_ready = m_active || m_drain;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_done = 1'b0; m_n = 0;
         m_img_a = '0; m_bias_a = '0; m_img_b = '0; m_bias_b = '0;
      end else begin
         m_done = 1'b0;
         if (!m_active && !m_drain) begin
            if (start) begin
               m_active = 1'b1; m_n = 0; m_err = 1'b0;
            end
         end else if (s_valid) begin
            if (m_drain) begin
               if (s_last) m_drain = 1'b0;
            end else begin
               m_w[m_n] = s_data;
               m_n++;
               if (m_n == FRAME) begin
                  m_active = 1'b0;
                  if (s_last) begin
                     for (int k = 0; k < 2; k++) begin
                        m_img_a[k*32 +: 32]  = m_w[k];
                        m_bias_a[k*32 +: 32] = m_w[2+k];
                     end
                     m_img_b = m_w[0];
                     for (int k = 0; k < 3; k++) m_bias_b[k*32 +: 32] = m_w[1+k];
                     m_done = 1'b1;
                  end else begin
                     m_err = 1'b1; m_drain = 1'b1;
                  end
               end else if (s_last) begin
                  m_err = 1'b1; m_active = 1'b0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("a_ready", s_ready_a, m_ready);
      check("a_busy",  busy_a,    m_ready);
      check("a_done",  done_a,    m_done);
      check("a_error", error_a,   m_err);
      check("a_image", image_a,   m_img_a);
      check("a_bias",  bias_a,    m_bias_a);
      check("b_ready", s_ready_b, m_ready);
      check("b_busy",  busy_b,    m_ready);
      check("b_done",  done_b,    m_done);
      check("b_error", error_b,   m_err);
      check("b_image", image_b,   m_img_b);
      check("b_bias",  bias_b,    m_bias_b);
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      bit acc = 1'b0;
      int waited = 0;
      s_valid = 1'b1; s_data = d; s_last = l;
      while (!acc && waited < 20) begin
         @(negedge clk);
         acc = m_ready;
         cycle();
         waited++;
      end
      if (!acc) check("send_timeout", 1'b0, 1'b1);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   initial begin
      int done_b0;
      @(negedge clk);
      check("rst_ready", s_ready_a, 1'b0);
      check("rst_image", image_a, 64'h0);
      check("rst_bias_b", bias_b, 96'h0);
      #2 rst_n = 1'b1;
      cycle();

      // Nominal back-to-back frame
      do_start();
      send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0); send(32'h44, 1'b1);
      check("nom_done",   done_a, 1'b1);
      check("nom_busy",   busy_a, 1'b0);
      check("nom_image",  image_a, 64'h00000022_00000011);
      check("nom_bias",   bias_a,  64'h00000044_00000033);
      check("nom_image_b", image_b, 32'h11);
      check("nom_bias_b",  bias_b,  96'h00000044_00000033_00000022);
      check("nom_error",  error_a, 1'b0);
      cycle();

      // Gapped stream with a stray start mid-frame
      do_start();
      send(32'h11, 1'b0);
      cycle();
      start = 1'b1;
      send(32'h22, 1'b0);
      start = 1'b0;
      cycle();
      send(32'h33, 1'b0);
      cycle();
      send(32'h44, 1'b1);
      check("gap_done",  done_a, 1'b1);
      check("gap_image", image_a, 64'h00000022_00000011);
      cycle();
      check("gap_no_extra_done", done_a, 1'b0);
      check("gap_done_count", done_cnt_a, 2);

      // Early s_last on the second beat
      do_start();
      send(32'h11, 1'b0); send(32'h22, 1'b1);
      check("early_error", error_a, 1'b1);
      check("early_done",  done_a, 1'b0);
      check("early_busy",  busy_a, 1'b0);
      check("early_image", image_a, 64'h00000022_00000011);
      check("early_bias",  bias_a,  64'h00000044_00000033);
      cycle();

      // Next good frame; start clears error
      do_start();
      check("restart_error_clr", error_a, 1'b0);
      send(32'hA1, 1'b0); send(32'hA2, 1'b0); send(32'hA3, 1'b0); send(32'hA4, 1'b1);
      check("good_image", image_a, 64'h000000A2_000000A1);
      check("good_bias",  bias_a,  64'h000000A4_000000A3);
      cycle();

      // Missing s_last then drain
      do_start();
      send(32'h1, 1'b0); send(32'h2, 1'b0); send(32'h3, 1'b0); send(32'h4, 1'b0);
      check("miss_error", error_a, 1'b1);
      check("miss_ready", s_ready_a, 1'b1);
      check("miss_busy",  busy_a, 1'b1);
      send(32'h55, 1'b0);
      check("drain_ready", s_ready_a, 1'b1);
      send(32'h66, 1'b1);
      check("drain_busy",  busy_a, 1'b0);
      check("drain_done",  done_a, 1'b0);
      check("drain_image", image_a, 64'h000000A2_000000A1);
      cycle();

      // Async reset in the middle of LOAD_BIAS
      do_start();
      send(32'hB1, 1'b0); send(32'hB2, 1'b0); send(32'hB3, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_image", image_a, 64'h0);
      check("arst_bias",  bias_a,  64'h0);
      check("arst_error", error_a, 1'b0);
      check("arst_ready", s_ready_a, 1'b0);
      check("arst_bias_b", bias_b, 96'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      cycle();

      // Frame after reset; exercises the 1/3 split explicitly
      done_b0 = done_cnt_b;
      do_start();
      send(32'h5, 1'b0); send(32'h6, 1'b0); send(32'h7, 1'b0); send(32'h8, 1'b1);
      cycle();
      cycle();
      check("split_image_b", image_b, 32'h5);
      check("split_bias_b",  bias_b,  96'h00000008_00000007_00000006);
      check("split_image_a", image_a, 64'h00000006_00000005);
      check("split_done_once", done_cnt_b - done_b0, 1);
      check("total_done_a", done_cnt_a, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/layer_loader.md
Name: layer_loader

Overview:
- Write-side counterpart to the layer's parallel image/bias inputs.
- Accepts a serial valid/ready stream of 32-bit words and assembles a packed image vector (NUM_IN words) and bias vector (NUM_OUT words).
- Commits both vectors atomically to its outputs, which feed a layer in place of the file-based loaders.
- Staging is double-buffered, so the layer sees a stable previous frame while the next one loads.

Parameters:
- NUM_IN, 4: number of image words per frame (≥1).
- NUM_OUT, 4: number of bias words per frame (≥1).
- DATA_W, 32: word width, fixed at 32 for layer compatibility.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin loading a frame; sampled only in IDLE.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader accepts a word.
- s_data  in  32  stream word.
- s_last  in  1  marks the final word of a frame.
- image  out  NUM_IN*32  committed image; word k at [k*32 +: 32].
- bias  out  NUM_OUT*32  committed biases; word k at [k*32 +: 32].
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a frame commits.
- error  out  1  sticky frame-length error flag.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; image, bias, staging, and counter all zero; s_ready=0, busy=0, done=0, error=0.
- Handshake: a beat transfers on a rising edge where s_valid && s_ready. s_ready is a registered function of state: 1 in LOAD_IMG, LOAD_BIAS, and DRAIN; 0 in IDLE.
- Frame order: NUM_IN image words (index 0 first), then NUM_OUT bias words (index 0 first). Total frame length = NUM_IN+NUM_OUT beats, with s_last required on the final beat only.
- States:
  - IDLE: start=1 → LOAD_IMG; cnt=0; error cleared. start in any other state is ignored.
  - LOAD_IMG: each beat writes stage_img[cnt] and increments cnt. On the beat with cnt==NUM_IN-1 → LOAD_BIAS, cnt=0.
  - LOAD_BIAS: each beat writes stage_bias[cnt] and increments cnt.
  - On the beat with cnt==NUM_OUT-1:
    - If s_last=1 → commit, then IDLE.
    - If s_last=0 → error=1, no commit, → DRAIN.
  - Early s_last (any beat before the final one, in LOAD_IMG or LOAD_BIAS): error=1, no commit, → IDLE. That beat is consumed.
  - DRAIN: discard beats until one with s_last=1 is accepted, then → IDLE. No commit.
- Commit: on the edge accepting the final beat, image<=stage_img and bias<=stage_bias (final word merged directly), and done<=1. Outputs therefore update, and done is high, in the cycle immediately after the final handshake. done is low in all other cycles.
- Latency: a back-to-back stream of NUM_IN+NUM_OUT beats starting the cycle after start gives done in cycle start+1+NUM_IN+NUM_OUT.
- Stalls: s_valid=0 holds all state. Outputs never change except on commit or reset.
- Failed frames: image and bias keep the last committed frame.
- Reset mid-frame: everything is zeroed immediately (including committed outputs), state=IDLE.
- Counter width: $clog2 of max(NUM_IN, NUM_OUT, 2). No wrap occurs because cnt resets at each phase boundary.
- busy=1 in LOAD_IMG, LOAD_BIAS, and DRAIN.

Decomposition:
- Shared package nn_pkg holds:
  - WORD_W=32 constant.
  - State enum loader_state_t {IDLE, LOAD_IMG, LOAD_BIAS, DRAIN}, also used by future layer controllers.
- One natural sub-module: word_stager, a parameterized N-word register file with indexed write and a packed read vector. It is instantiated twice (image, bias).
- FSM and commit logic stay in layer_loader.

Test Plan (NUM_IN=2, NUM_OUT=2 unless stated):
- Nominal: start, then beats 0x11,0x22,0x33,0x44 (s_last on 0x44), back-to-back → done one cycle after the last beat; image=0x00000022_00000011, bias=0x00000044_00000033; error=0; busy falls with done.
- Backpressure/gaps: same frame with s_valid toggling 1,0,1,0 and start pulsed again mid-frame → identical result; the second start is ignored; no extra done.
- Early s_last on the 2nd beat (0x22) → error=1, no done, state IDLE. Outputs hold the prior frame (0x...22_...11 / 0x...44_...33). The next good frame (0xA1..0xA4) commits and the new start clears error.
- Missing s_last on the 4th beat, then two extra beats with s_last on the second → error=1, s_ready stays high through DRAIN, no commit, busy drops after the s_last beat.
- Async reset asserted mid-LOAD_BIAS (between clock edges) → image, bias, and error zero immediately; s_ready=0; a following full frame commits normally.
- NUM_IN=1, NUM_OUT=3: beats 0x5,0x6,0x7,0x8 → image=0x5, bias=0x00000008_00000007_00000006; done asserts exactly once.
